// File: rtl/stream_resize_pkg.sv
// Shared helpers for the stream_resize family (upsize/downsize width converters).
// Lane masks and parameter legality checks used at elaboration and in datapaths.
package stream_resize_pkg;

    localparam int MAX_RATIO = 64;

    // Contiguous ones in lanes [count-1:0], zeros above.
    function automatic logic [MAX_RATIO-1:0] keep_mask(input int count);
        logic [MAX_RATIO-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_RATIO; i++) begin
            m[i] = (i < count);
        end
        return m;
    endfunction

    function automatic bit ratio_ok(input int ratio);
        return (ratio >= 2) && (ratio <= MAX_RATIO);
    endfunction

endpackage

// File: rtl/stream_upsize_if.sv
// Narrow slave stream in, wide master stream out; slave modport is the converter's view.
interface stream_upsize_if #(
    parameter int T_DATA_WIDTH = 1,
    parameter int T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0] m_keep_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    modport slave (
        input  s_data_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );

    modport master (
        output s_data_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_keep_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_upsize.sv
// Packs T_DATA_RATIO narrow words (or a shorter packet tail) into one wide beat with lane keep.
// Latency 1 cycle; s_ready_o drops only while a completed beat waits behind a stalled output.
module stream_upsize
    import stream_resize_pkg::*;
#(
    parameter int T_DATA_WIDTH  = 1,
    parameter int T_DATA_RATIO  = 2,
    parameter int T_WIDTH_RATIO = $clog2(T_DATA_RATIO)
) (
    input  logic           clk,
    input  logic           rst,
    stream_upsize_if.slave bus
);

    if (!ratio_ok(T_DATA_RATIO)) begin : g_ratio_check
        $error("stream_upsize: T_DATA_RATIO must be in 2..%0d", MAX_RATIO);
    end

    logic [T_WIDTH_RATIO-1:0] idx_q, idx_d;
    logic [T_DATA_WIDTH-1:0]  acc_q [T_DATA_RATIO-1:0];
    logic [T_DATA_WIDTH-1:0]  acc_d [T_DATA_RATIO-1:0];
    logic                     pending_q, pending_d;
    logic                     pend_last_q, pend_last_d;
    logic [T_DATA_WIDTH-1:0]  m_data_q [T_DATA_RATIO-1:0];
    logic [T_DATA_WIDTH-1:0]  m_data_d [T_DATA_RATIO-1:0];
    logic [T_DATA_RATIO-1:0]  m_keep_q, m_keep_d;
    logic                     m_last_q, m_last_d;
    logic                     m_valid_q, m_valid_d;

    logic                     s_ready;
    logic                     s_xfer;
    logic                     out_free;
    logic                     beat_done;
    logic [T_DATA_RATIO-1:0]  cur_keep;

    assign s_ready = !pending_q && !rst;

    always_comb begin
        idx_d       = idx_q;
        acc_d       = acc_q;
        pending_d   = pending_q;
        pend_last_d = pend_last_q;
        m_data_d    = m_data_q;
        m_keep_d    = m_keep_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q && !bus.m_ready_i;

        out_free  = !m_valid_q || bus.m_ready_i;
        s_xfer    = bus.s_valid_i && s_ready;
        beat_done = (idx_q == T_WIDTH_RATIO'(T_DATA_RATIO - 1)) || bus.s_last_i;
        // idx is held while pending, so the lane count of the trapped beat is still idx+1.
        cur_keep  = T_DATA_RATIO'(keep_mask(int'(idx_q) + 1));

        if (pending_q) begin
            if (out_free) begin
                m_data_d  = acc_q;
                m_keep_d  = cur_keep;
                m_last_d  = pend_last_q;
                m_valid_d = 1'b1;
                pending_d = 1'b0;
                idx_d     = '0;
                for (int k = 0; k < T_DATA_RATIO; k++) acc_d[k] = '0;
            end
        end else if (s_xfer) begin
            acc_d[idx_q] = bus.s_data_i;
            if (!beat_done) begin
                idx_d = idx_q + 1'b1;
            end else if (out_free) begin
                m_data_d  = acc_d;
                m_keep_d  = cur_keep;
                m_last_d  = bus.s_last_i;
                m_valid_d = 1'b1;
                idx_d     = '0;
                for (int k = 0; k < T_DATA_RATIO; k++) acc_d[k] = '0;
            end else begin
                pending_d   = 1'b1;
                pend_last_d = bus.s_last_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            pending_q   <= 1'b0;
            pend_last_q <= 1'b0;
            m_keep_q    <= '0;
            m_last_q    <= 1'b0;
            m_valid_q   <= 1'b0;
            for (int k = 0; k < T_DATA_RATIO; k++) begin
                acc_q[k]    <= '0;
                m_data_q[k] <= '0;
            end
        end else begin
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            pending_q   <= pending_d;
            pend_last_q <= pend_last_d;
            m_data_q    <= m_data_d;
            m_keep_q    <= m_keep_d;
            m_last_q    <= m_last_d;
            m_valid_q   <= m_valid_d;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_keep_o  = m_keep_q;
    assign bus.m_last_o  = m_last_q;
    assign bus.m_valid_o = m_valid_q;

endmodule
